// File: rtl/rlwe_prog_loader_pkg.sv
// Shared types and header layout for the RLWE program loader.
package rlwe_loader_pkg;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        TRL     = 2'd2,
        ERR     = 2'd3
    } type_loader_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MAGIC    = 2'd1,
        ERR_LENGTH   = 2'd2,
        ERR_CHECKSUM = 2'd3
    } type_err_code_e;

    localparam logic [15:0] MAGIC_DEFAULT = 16'hA5C3;

    // Header word layout: magic in the upper half, count of 4-word groups below.
    localparam int HDR_MAGIC_MSB = 31;
    localparam int HDR_MAGIC_LSB = 16;
    localparam int HDR_COUNT_MSB = 15;
    localparam int HDR_COUNT_LSB = 0;

    // Wide enough for 4 * 65535 and for the 262144-word image limit.
    localparam int WL_W = 19;

endpackage

// File: rtl/rlwe_prog_loader_if.sv
// Host stream and instruction-FIFO write port of the program loader.
//
// Handshake: a host word transfers on a rising clk edge where host_valid and
// host_ready are both 1. host_ready is combinational from the loader state and
// the current-cycle full/almost_full flags, so it may drop from one cycle to
// the next; the host holds host_data stable while host_valid is high. The FIFO
// write side has no ready: enqueue_en is a one-cycle strobe with value_i.
interface rlwe_prog_loader_if #(
    parameter int WIDTH = 32
);
    logic             host_valid;
    logic             host_ready;
    logic [WIDTH-1:0] host_data;
    logic             full;
    logic             almost_full;
    logic             enqueue_en;
    logic [WIDTH-1:0] value_i;

    modport master (
        output host_valid, host_data, full, almost_full,
        input  host_ready, enqueue_en, value_i
    );

    modport slave (
        input  host_valid, host_data, full, almost_full,
        output host_ready, enqueue_en, value_i
    );
endinterface

// File: rtl/rlwe_prog_loader.sv
// Frame parser that validates host program images and pushes payload words
// into the core's instruction FIFO with one cycle of write latency.
module rlwe_prog_loader
    import rlwe_loader_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          MAX_WORDS = 262144,
    parameter logic [15:0] MAGIC     = MAGIC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    rlwe_prog_loader_if.slave   bus,
    input  logic                err_clr,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [WL_W-1:0]     words_loaded,
    output type_loader_state_e  dbg_state
);

    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

    type_loader_state_e state_q, state_d;
    type_err_code_e     err_code_q, err_code_d;
    logic [WL_W-1:0]    remaining_q, remaining_d;
    logic [WL_W-1:0]    words_q, words_d;
    logic [WIDTH-1:0]   checksum_q, checksum_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               enq_q, enq_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               ready_c;
    logic               xfer;
    logic [15:0]        hdr_magic;
    logic [15:0]        hdr_count;
    logic [WL_W-1:0]    payload_len;

    assign hdr_magic   = bus.host_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
    assign hdr_count   = bus.host_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
    assign payload_len = {1'b0, hdr_count, 2'b00};

    // Ready per state; almost_full leaves room for the registered write in flight.
    always_comb begin
        ready_c = 1'b0;
        unique case (state_q)
            HDR:     ready_c = 1'b1;
            PAYLOAD: ready_c = !bus.almost_full && !bus.full;
            TRL:     ready_c = 1'b1;
            default: ready_c = 1'b0;
        endcase
        if (rst) begin
            ready_c = 1'b0;
        end
    end

    assign xfer = bus.host_valid && ready_c;

    // Next-state, frame bookkeeping and registered FIFO write.
    always_comb begin
        state_d     = state_q;
        err_code_d  = err_code_q;
        remaining_d = remaining_q;
        words_d     = words_q;
        checksum_d  = checksum_q;
        value_d     = value_q;
        enq_d       = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            HDR: begin
                if (xfer) begin
                    if (hdr_magic != MAGIC) begin
                        state_d    = ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_MAGIC;
                    end else if ({{(32-WL_W){1'b0}}, payload_len} > MAX_WORDS_U) begin
                        state_d    = ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_LENGTH;
                    end else begin
                        // An empty frame goes straight to the trailer, which must then be 0.
                        state_d     = (hdr_count == 16'd0) ? TRL : PAYLOAD;
                        remaining_d = payload_len;
                        checksum_d  = '0;
                        words_d     = '0;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    enq_d       = 1'b1;
                    value_d     = bus.host_data;
                    checksum_d  = checksum_q + bus.host_data;
                    remaining_d = remaining_q - 1'b1;
                    words_d     = words_q + 1'b1;
                    if (remaining_q == {{(WL_W-1){1'b0}}, 1'b1}) begin
                        state_d = TRL;
                    end
                end
            end
            TRL: begin
                if (xfer) begin
                    if (bus.host_data == checksum_q) begin
                        state_d = HDR;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
            end
            ERR: begin
                if (err_clr) begin
                    state_d    = HDR;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = HDR;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            err_code_q  <= ERR_NONE;
            remaining_q <= '0;
            words_q     <= '0;
            checksum_q  <= '0;
            value_q     <= '0;
            enq_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_code_q  <= err_code_d;
            remaining_q <= remaining_d;
            words_q     <= words_d;
            checksum_q  <= checksum_d;
            value_q     <= value_d;
            enq_q       <= enq_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.host_ready = ready_c;
    assign bus.enqueue_en = enq_q;
    assign bus.value_i    = value_q;
    assign busy           = (state_q == PAYLOAD) || (state_q == TRL);
    assign done           = done_q;
    assign err            = err_q;
    assign err_code       = err_code_q;
    assign words_loaded   = words_q;
    assign dbg_state      = state_q;

endmodule
